// File: rtl/spi_cfg_regbank.sv
// Addressed SPI configuration register bank with shadow storage.
// Writes commit atomically on frame end; registers can be read back.
module spi_cfg_regbank #(
  parameter int NREG = 8,
  parameter logic [NREG*8-1:0] RESET_VAL = '0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_csn,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [NREG*8-1:0] cfg_out,
  output logic              cfg_update,
  output logic              frame_err
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [7:0] NREG8 = 8'(NREG);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sck_s;
  logic [SYNC_STAGES-1:0] csn_s;
  logic [SYNC_STAGES-1:0] mosi_s;
  logic sck_d, csn_d;
  logic sck_rise, sck_fall;
  logic csn_rise, csn_fall;
  logic mosi_q;

  logic [2:0]        bcnt;
  logic [6:0]        shreg;
  logic              wr;
  logic [6:0]        addr;
  logic              ld_pend;
  logic [7:0]        miso_sr;
  logic [NREG*8-1:0] shadow;
  logic [NREG-1:0]   dirty;

  logic [7:0]        shift_nx;
  logic              in_range;
  logic [7:0]        rd_byte;
  logic [NREG*8-1:0] mask;

  // csn chain resets low so a CSn held low across reset is not a new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s    <= '0;
      csn_s    <= '0;
      mosi_s   <= '0;
      sck_d    <= 1'b0;
      csn_d    <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      csn_rise <= 1'b0;
      csn_fall <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      sck_s    <= {sck_s[SYNC_STAGES-2:0], spi_sck};
      csn_s    <= {csn_s[SYNC_STAGES-2:0], spi_csn};
      mosi_s   <= {mosi_s[SYNC_STAGES-2:0], spi_mosi};
      sck_d    <= sck_s[SYNC_STAGES-1];
      csn_d    <= csn_s[SYNC_STAGES-1];
      sck_rise <= sck_s[SYNC_STAGES-1] & ~sck_d;
      sck_fall <= ~sck_s[SYNC_STAGES-1] & sck_d;
      csn_rise <= csn_s[SYNC_STAGES-1] & ~csn_d;
      csn_fall <= ~csn_s[SYNC_STAGES-1] & csn_d;
      mosi_q   <= mosi_s[SYNC_STAGES-1];
    end
  end

  always_comb begin
    shift_nx = {shreg, mosi_q};
    in_range = ({1'b0, addr} < NREG8);
    rd_byte  = 8'h00;
    if (in_range)
      rd_byte = cfg_out[{addr[AW-1:0], 3'b000} +: 8];
    mask = '0;
    for (int k = 0; k < NREG; k++)
      mask[8*k +: 8] = {8{dirty[k]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      csn_fall: state_nx = CMD;
      csn_rise: state_nx = IDLE;
      default: begin
        if (state == CMD && sck_rise && bcnt == 3'd7)
          state_nx = DATA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt       <= '0;
      shreg      <= '0;
      wr         <= 1'b0;
      addr       <= '0;
      ld_pend    <= 1'b0;
      miso_sr    <= '0;
      shadow     <= RESET_VAL;
      dirty      <= '0;
      cfg_out    <= RESET_VAL;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
      if (csn_fall) begin
        bcnt    <= '0;
        ld_pend <= 1'b0;
        miso_sr <= '0;
      end else if (csn_rise) begin
        bcnt    <= '0;
        ld_pend <= 1'b0;
        miso_sr <= '0;
        dirty   <= '0;
        if (bcnt == 3'd0) begin
          cfg_out    <= (cfg_out & ~mask) | (shadow & mask);
          cfg_update <= |dirty;
        end else begin
          frame_err <= 1'b1;
        end
      end else if (state != IDLE) begin
        if (sck_rise) begin
          shreg <= shift_nx[6:0];
          bcnt  <= bcnt + 3'd1;
          if (bcnt == 3'd7) begin
            if (state == CMD) begin
              wr      <= shift_nx[7];
              addr    <= shift_nx[6:0];
              ld_pend <= ~shift_nx[7];
            end else begin
              if (wr && in_range) begin
                shadow[{addr[AW-1:0], 3'b000} +: 8] <= shift_nx;
                dirty[addr[AW-1:0]] <= 1'b1;
              end
              addr    <= addr + 7'd1;
              ld_pend <= ~wr;
            end
          end
        end
        // read data moves on SCK fall so it is stable for the master's rise
        if (sck_fall && state == DATA && !wr) begin
          if (ld_pend) begin
            miso_sr <= rd_byte;
            ld_pend <= 1'b0;
          end else begin
            miso_sr <= {miso_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign spi_miso = miso_sr[7];

endmodule

// File: tb/tb_spi_cfg_regbank.sv
// Directed table-driven bench for spi_cfg_regbank.
// Frames are bit-banged on the SPI pins and checked on cfg_out/miso.
module tb_spi_cfg_regbank;

  localparam int NREG = 8;
  localparam logic [63:0] RV = 64'h0807060504030201;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_csn = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [63:0] cfg_out;
  logic        cfg_update;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_cfg_regbank #(
    .NREG(NREG),
    .RESET_VAL(RV),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_sck(spi_sck),
    .spi_csn(spi_csn),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .cfg_out(cfg_out),
    .cfg_update(cfg_update),
    .frame_err(frame_err)
  );

  typedef struct {
    string       name;
    int          nb;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          part;
    bit          rd;
    logic [15:0] exp_rd;
    logic [63:0] exp_cfg;
    int          exp_upd;
    int          exp_err;
  } vec_t;

  vec_t v[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic end_frame(output int upd, output int err, output int bad);
    logic [63:0] prev;
    upd = 0;
    err = 0;
    bad = 0;
    repeat (HALF) @(negedge clk);
    spi_csn = 1'b1;
    prev = cfg_out;
    repeat (20) begin
      @(negedge clk);
      if (cfg_update) upd++;
      if (frame_err) err++;
      if (cfg_out !== prev && !cfg_update) bad++;
      prev = cfg_out;
    end
  endtask

  initial begin
    logic [7:0]  rx0, rx1, rx2, rxp;
    logic [63:0] old;
    int upd, err, bad;

    v[0] = '{"wr2_3", 3, 8'h82, 8'hA5, 8'h3C, 0, 1'b0, 16'h0000,
             64'h080706053CA50201, 1, 0};
    v[1] = '{"rd2_3", 3, 8'h02, 8'h00, 8'h00, 0, 1'b1, 16'hA53C,
             64'h080706053CA50201, 0, 0};
    v[2] = '{"abort", 2, 8'h81, 8'hFF, 8'h00, 4, 1'b0, 16'h0000,
             64'h080706053CA50201, 0, 1};
    v[3] = '{"cmdonly", 1, 8'h85, 8'h00, 8'h00, 0, 1'b0, 16'h0000,
             64'h080706053CA50201, 0, 0};
    v[4] = '{"wr1", 2, 8'h81, 8'h55, 8'h00, 0, 1'b0, 16'h0000,
             64'h080706053CA55501, 1, 0};
    v[5] = '{"wr7_rng", 3, 8'h87, 8'h11, 8'h22, 0, 1'b0, 16'h0000,
             64'h110706053CA55501, 1, 0};
    v[6] = '{"rd7f_wrap", 3, 8'h7F, 8'h00, 8'h00, 0, 1'b1, 16'h0001,
             64'h110706053CA55501, 0, 0};
    v[7] = '{"rd1_2", 3, 8'h01, 8'h00, 8'h00, 0, 1'b1, 16'h55A5,
             64'h110706053CA55501, 0, 0};

    repeat (5) @(negedge clk);
    chk("rst_cfg", cfg_out, RV);
    chk("rst_miso", {63'd0, spi_miso}, 64'd0);
    rst_n = 1'b1;
    upd = 0;
    err = 0;
    repeat (12) begin
      @(negedge clk);
      if (cfg_update) upd++;
      if (frame_err) err++;
    end
    chk("post_rst_cfg", cfg_out, RV);
    chk("post_rst_upd", 64'(upd), 64'd0);
    chk("post_rst_err", 64'(err), 64'd0);

    for (int i = 0; i < 8; i++) begin
      old = cfg_out;
      rx1 = '0;
      rx2 = '0;
      spi_csn = 1'b0;
      repeat (HALF) @(negedge clk);
      xfer(v[i].b0, 8, rx0);
      chk({v[i].name, "_cmd_miso"}, 64'(rx0), 64'd0);
      if (v[i].nb > 1) xfer(v[i].b1, 8, rx1);
      if (v[i].nb > 2) xfer(v[i].b2, 8, rx2);
      if (v[i].part > 0) xfer(8'hF0, v[i].part, rxp);
      chk({v[i].name, "_hold"}, cfg_out, old);
      end_frame(upd, err, bad);
      chk({v[i].name, "_upd"}, 64'(upd), 64'(v[i].exp_upd));
      chk({v[i].name, "_err"}, 64'(err), 64'(v[i].exp_err));
      chk({v[i].name, "_atomic"}, 64'(bad), 64'd0);
      chk({v[i].name, "_cfg"}, cfg_out, v[i].exp_cfg);
      if (v[i].rd)
        chk({v[i].name, "_rd"}, 64'({rx1, rx2}), 64'(v[i].exp_rd));
      else
        chk({v[i].name, "_wr_miso"}, 64'({rx1, rx2}), 64'd0);
      chk({v[i].name, "_idle_miso"}, {63'd0, spi_miso}, 64'd0);
      repeat (HALF) @(negedge clk);
    end

    // reset in the middle of a write frame with CSn kept low
    spi_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(8'h83, 8, rx0);
    xfer(8'h99, 8, rx1);
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_cfg", cfg_out, RV);
    chk("midrst_miso", {63'd0, spi_miso}, 64'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    end_frame(upd, err, bad);
    chk("midrst_upd", 64'(upd), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_cfg2", cfg_out, RV);

    // clean frame after reset still works
    repeat (HALF) @(negedge clk);
    spi_csn = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(8'h80, 8, rx0);
    xfer(8'hAA, 8, rx1);
    end_frame(upd, err, bad);
    chk("after_rst_upd", 64'(upd), 64'd1);
    chk("after_rst_cfg", cfg_out, 64'h08070605040302AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cfg_regbank.md
# spi_cfg_regbank

Addressed, parametrised SPI configuration register bank for the FM transmitter. It replaces the flat SPI shift-register config with `NREG` byte-wide registers behind a command/address protocol. Writes go to shadow storage and commit atomically when the frame ends, so configuration outputs never toggle while a frame is loading. Register values can be read back. The SPI pins are oversampled in the system clock domain, so all outputs are synchronous to `clk`.

## Interface
- `NREG`, 8: number of 8-bit registers, 1..128.
- `RESET_VAL`, {NREG*8{1'b0}}: reset/default contents; register k occupies bits [8k+7:8k].
- `SYNC_STAGES`, 2: synchroniser depth for `spi_sck`, `spi_csn` and `spi_mosi`; must be ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `spi_sck`  in  1  SPI clock (mode 0), asynchronous to `clk`.
- `spi_csn`  in  1  chip select, active-low.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out, registered, MSB first.
- `cfg_out`  out  NREG*8  committed register contents.
- `cfg_update`  out  1  one-cycle pulse in the cycle `cfg_out` changes due to a commit.
- `frame_err`  out  1  one-cycle pulse when a frame ends on a partial byte.

## Operation
- Inputs pass through `SYNC_STAGES` flops. SCK rise/fall and CSn fall/rise are detected by comparing the last synchronised sample with the previous one.
- Frame format: the command byte is `{wr, addr[6:0]}`, followed by zero or more data bytes. Address auto-increments after each data byte, modulo 128.
- FSM states:
  - IDLE: CSn high. CSn fall goes to CMD.
  - CMD: shift 8 bits on SCK rise. After the 8th bit, latch `wr`/`addr` and go to DATA.
  - DATA: shift 8 bits per byte, with the bit counter wrapping at 8.
  - CSn rise from any state goes to IDLE. CSn fall in any state restarts CMD with the bit count cleared.
- Write data byte: stored to `shadow[addr]`, and `dirty[addr]` is set. For `addr ≥ NREG` the byte is discarded.
- Frame end (CSn rise):
  - If bit count is 0, copy every dirty shadow register to active. If any register was dirty, pulse `cfg_update`.
  - If bit count is nonzero, commit nothing and pulse `frame_err`.
  - In both cases clear all dirty bits.
- A frame with only a command byte, or a read frame, never asserts `cfg_update`.
- Read: on the SCK fall following the 8th command bit, load the output shifter with `active[addr]`, or 0x00 if `addr ≥ NREG`. `spi_miso` presents bit 7. On each subsequent SCK fall, shift left. After each 8th data bit, load the next address.
- `spi_miso` is 0 during the command byte, during write frames, and while CSn is high.
- Reset (`rst_n` low), including mid-frame: `cfg_out`=`RESET_VAL`, shadow=`RESET_VAL`, dirty=0, FSM=IDLE, counters 0, `spi_miso`=0, `cfg_update`=0, `frame_err`=0. A frame in progress is lost. After reset release, the next CSn fall starts a clean frame; if CSn is already low, nothing happens until CSn rises and falls again.

## Timing
- SCK high and low phases must each be ≥ `SYNC_STAGES`+2 `clk` periods. CSn setup/hold to the first/last SCK edge must be ≥ `SYNC_STAGES`+2 periods.
- MOSI is sampled from the synchronised stream in the same cycle the SCK rise is detected. The MOSI and SCK sync paths have equal depth.
- `spi_miso` updates `SYNC_STAGES`+1 `clk` cycles after the SCK falling pin edge, and is valid well before the next SCK rise given the phase constraint.
- Commit latency: `cfg_out` and `cfg_update` change `SYNC_STAGES`+1 cycles after the first `clk` edge that samples `spi_csn` high. `frame_err` has the same latency.
- `cfg_out` is constant between commits. All bytes of one frame update in the same cycle.

## Test plan
- Reset with `RESET_VAL` = 0x0807060504030201 → `cfg_out`=0x0807060504030201; `spi_miso`, `cfg_update`, `frame_err` = 0.
- Write frame 0x82, 0xA5, 0x3C → `cfg_out` unchanged until CSn rise, then reg2=0xA5 and reg3=0x3C in one cycle, with `cfg_update` high for exactly 1 cycle; other registers unchanged.
- Read frame 0x02 plus 16 SCK cycles → MISO returns 0xA5 then 0x3C; `cfg_update` stays 0.
- Aborted write: 0x81, 0xFF, then 4 bits, CSn rise → `cfg_out` unchanged, `frame_err` pulses once. A following clean write 0x81, 0x55 commits only reg1=0x55.
- Range/wrap: write 0x87, 0x11, 0x22 → reg7=0x11 and addr 8 is ignored. Read 0x7F plus 16 SCK cycles → 0x00, then reg0's value (wrap to 0).
- `rst_n` pulsed low after 0x83 and 0x99 are shifted, with CSn held low → `cfg_out`=`RESET_VAL`. A CSn rise after release produces no `cfg_update` and no `frame_err`.
